// File: rtl/tick_generator.sv
// Multi-channel divider: per-channel square wave, period tick and divisor-accept strobe.
// Each channel runs its own IDLE/RUN machine. A new divisor is taken only at a half-period boundary.
module tick_generator #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 26
) (
  input  logic                    clkin,
  input  logic                    rst_N,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] ch_div,
  input  logic                    sync_clr,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_ack
);

  // state   | meaning
  // ST_IDLE | channel stopped, counter and clk_out held at 0
  // ST_RUN  | counting up to r_act_div, toggling clk_out at each terminal count
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state   [NUM_CH];
  logic [CNT_W-1:0] r_cnt     [NUM_CH];
  logic [CNT_W-1:0] r_act_div [NUM_CH];

  always_ff @(posedge clkin or negedge rst_N) begin
    if (!rst_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]   <= ST_IDLE;
        r_cnt[i]     <= '0;
        r_act_div[i] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
      div_ack <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tick[i]    <= 1'b0;
        div_ack[i] <= 1'b0;
        case (r_state[i])
          ST_IDLE: begin
            r_cnt[i]   <= '0;
            clk_out[i] <= 1'b0;
            if (ch_en[i]) begin
              r_state[i]   <= ST_RUN;
              r_act_div[i] <= ch_div[i*CNT_W +: CNT_W];
              div_ack[i]   <= 1'b1;
            end
          end
          ST_RUN: begin
            // Priority: disable, then phase-align, then terminal count.
            if (!ch_en[i]) begin
              r_state[i] <= ST_IDLE;
              r_cnt[i]   <= '0;
              clk_out[i] <= 1'b0;
            end else if (sync_clr) begin
              r_cnt[i]     <= '0;
              clk_out[i]   <= 1'b0;
              r_act_div[i] <= ch_div[i*CNT_W +: CNT_W];
              div_ack[i]   <= (ch_div[i*CNT_W +: CNT_W] != r_act_div[i]);
            end else if (r_cnt[i] == r_act_div[i]) begin
              r_cnt[i]     <= '0;
              clk_out[i]   <= ~clk_out[i];
              tick[i]      <= ~clk_out[i];
              r_act_div[i] <= ch_div[i*CNT_W +: CNT_W];
              div_ack[i]   <= (ch_div[i*CNT_W +: CNT_W] != r_act_div[i]);
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
